// File: rtl/imm_pkg.sv
// Shared definitions for the immediate decode stage.
// Holds the RV32I/RV64I major opcodes, the output format codes and a
// helper that spots shift-immediate funct3 encodings.
// Optional feature macro used elsewhere: IMM_ZICSR_EN (CSR zimm decode).
package imm_pkg;

  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_RSVD = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // SLLI (001) and SRLI/SRAI (101) carry a shift amount instead of an immediate.
  function automatic logic isShiftImm(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate decode stage.
// Upstream channel : in_valid, in_ready, in_instr, in_tag
// Downstream channel: out_valid, out_ready, out_imm, out_fmt, out_illegal, out_tag
// Modports: master = the environment (fetch + register-read side),
//           slave  = the decode stage itself.
interface imm_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);

  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_imm;
  logic [imm_pkg::FMT_W-1:0] out_fmt;
  logic                     out_illegal;
  logic [TAG_W-1:0]         out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extractor for RV32I/RV64I.
// Ports:
//   i_instr   in  32    instruction word
//   o_imm     out XLEN  sign-/zero-extended immediate
//   o_fmt     out 3     format code (imm_fmt_e)
//   o_illegal out 1     opcode not recognised
// Parameter XLEN: 32 or 64 (64 enables OP-IMM-32/OP-32 and 6-bit shamt).
// Macro IMM_ZICSR_EN: when defined, CSR immediate forms produce FMT_Z.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      i_instr,
  output logic [XLEN-1:0]  o_imm,
  output logic [FMT_W-1:0] o_fmt,
  output logic             o_illegal
);

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic signed [31:0] w_immI;
  logic signed [31:0] w_immS;
  logic signed [31:0] w_immB;
  logic signed [31:0] w_immU;
  logic signed [31:0] w_immJ;
  logic signed [31:0] w_imm32;
  imm_fmt_e           w_fmt;
  logic               w_illegal;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];

  // Every format sign-extends from instruction bit 31.
  assign w_immI = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_immS = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_immB = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_immU = {i_instr[31:12], 12'b0};
  assign w_immJ = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Opcode dispatch. Anything not listed (including bits[1:0] != 2'b11) is illegal.
  always_comb begin
    w_imm32   = '0;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_LOAD, OPC_JALR: begin
        w_fmt   = FMT_I;
        w_imm32 = w_immI;
      end
      OPC_OP_IMM: begin
        w_fmt = FMT_I;
        if (isShiftImm(w_funct3)) begin
          w_imm32 = (XLEN == 64) ? {26'b0, i_instr[25:20]} : {27'b0, i_instr[24:20]};
        end else begin
          w_imm32 = w_immI;
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          w_fmt   = FMT_I;
          w_imm32 = isShiftImm(w_funct3) ? {27'b0, i_instr[24:20]} : w_immI;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        w_fmt   = FMT_S;
        w_imm32 = w_immS;
      end
      OPC_BRANCH: begin
        w_fmt   = FMT_B;
        w_imm32 = w_immB;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_fmt   = FMT_U;
        w_imm32 = w_immU;
      end
      OPC_JAL: begin
        w_fmt   = FMT_J;
        w_imm32 = w_immJ;
      end
      OPC_OP, OPC_MISC_MEM: begin
        w_fmt = FMT_NONE;
      end
      OPC_OP_32: begin
        w_illegal = (XLEN != 64);
      end
      OPC_SYSTEM: begin
`ifdef IMM_ZICSR_EN
        // CSRRWI/CSRRSI/CSRRCI carry a 5-bit unsigned zimm in the rs1 field.
        if (w_funct3[2] && (w_funct3[1:0] != 2'b00)) begin
          w_fmt   = FMT_Z;
          w_imm32 = {27'b0, i_instr[19:15]};
        end
`else
        w_fmt = FMT_NONE;
`endif
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // The signed 32-bit intermediate widens by sign extension; zero-extended
  // forms are small positive values so this is harmless for them.
  assign o_imm     = XLEN'(w_imm32);
  assign o_fmt     = w_fmt;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage with a 2-entry skid buffer.
// Instructions are decoded combinationally at the input by imm_extract and
// the result is captured into the main register (which drives out_*) or,
// when the main register is stalled, into the skid register.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous active-high reset
//   flush in  1  drop every buffered entry (branch redirect)
//   bus   slave modport of imm_decode_stage_if (in_* / out_* handshake)
// Parameters: XLEN (32/64), TAG_W (sideband tag width).
// Macro IMM_ZICSR_EN: enables CSR zimm decoding inside imm_extract.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  imm_decode_stage_if.slave  bus
);

  logic [XLEN-1:0]  w_extImm;
  logic [FMT_W-1:0] w_extFmt;
  logic             w_extIllegal;
  logic             w_accept;
  logic             w_fire;

  logic             r_mainValid;
  logic [XLEN-1:0]  r_mainImm;
  logic [FMT_W-1:0] r_mainFmt;
  logic             r_mainIllegal;
  logic [TAG_W-1:0] r_mainTag;

  logic             r_skidValid;
  logic [XLEN-1:0]  r_skidImm;
  logic [FMT_W-1:0] r_skidFmt;
  logic             r_skidIllegal;
  logic [TAG_W-1:0] r_skidTag;

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .i_instr   (bus.in_instr),
    .o_imm     (w_extImm),
    .o_fmt     (w_extFmt),
    .o_illegal (w_extIllegal)
  );

  // Ready depends only on stored state (and reset), never on out_ready,
  // so downstream stalls cannot ripple combinationally back to fetch.
  assign bus.in_ready = ~r_skidValid & ~rst;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_fire       = r_mainValid & bus.out_ready;

  // Main/skid update. The main register refills from skid first so that
  // ordering is preserved; skid only fills when main is held by a stall.
  // Flush clears both valids and wins over any simultaneous accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mainValid   <= 1'b0;
      r_mainImm     <= '0;
      r_mainFmt     <= '0;
      r_mainIllegal <= 1'b0;
      r_mainTag     <= '0;
      r_skidValid   <= 1'b0;
      r_skidImm     <= '0;
      r_skidFmt     <= '0;
      r_skidIllegal <= 1'b0;
      r_skidTag     <= '0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (!r_mainValid || w_fire) begin
      if (r_skidValid) begin
        r_mainValid   <= 1'b1;
        r_mainImm     <= r_skidImm;
        r_mainFmt     <= r_skidFmt;
        r_mainIllegal <= r_skidIllegal;
        r_mainTag     <= r_skidTag;
        r_skidValid   <= 1'b0;
      end else if (w_accept) begin
        r_mainValid   <= 1'b1;
        r_mainImm     <= w_extImm;
        r_mainFmt     <= w_extFmt;
        r_mainIllegal <= w_extIllegal;
        r_mainTag     <= bus.in_tag;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skidValid   <= 1'b1;
      r_skidImm     <= w_extImm;
      r_skidFmt     <= w_extFmt;
      r_skidIllegal <= w_extIllegal;
      r_skidTag     <= bus.in_tag;
    end
  end

  assign bus.out_valid   = r_mainValid;
  assign bus.out_imm     = r_mainImm;
  assign bus.out_fmt     = r_mainFmt;
  assign bus.out_illegal = r_mainIllegal;
  assign bus.out_tag     = r_mainTag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed scenarios plus a long
// randomized run, all checked every cycle against a queue-based model.
// Honours IMM_ZICSR_EN the same way as the design.
module tb_imm_decode_stage;

  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  int   nChecks;
  int   nFails;
  bit   done;
  bit   zeroFlag;
  exp_t model[$];

  imm_decode_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  imm_decode_stage #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written directly from the format rules as integer arithmetic.
  function automatic void modelDecode(input logic [31:0] ins, output exp_t e);
    longint v;
    int op;
    int f3;
    bit zicsr;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    v = 0;
    e.tag = '0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
`ifdef IMM_ZICSR_EN
    zicsr = 1'b1;
`else
    zicsr = 1'b0;
`endif
    if (op == 'h03 || op == 'h67 || op == 'h13 || (op == 'h1B && XLEN == 64)) begin
      e.fmt = 3'd1;
      if ((op == 'h13 || op == 'h1B) && (f3 == 1 || f3 == 5)) begin
        v = (XLEN == 64 && op == 'h13) ? ((ins >> 20) & 63) : ((ins >> 20) & 31);
      end else begin
        v = (ins >> 20) & 4095;
        if (v >= 2048) v -= 4096;
      end
    end else if (op == 'h23) begin
      e.fmt = 3'd2;
      v = (((ins >> 25) & 127) << 5) | ((ins >> 7) & 31);
      if (v >= 2048) v -= 4096;
    end else if (op == 'h63) begin
      e.fmt = 3'd3;
      v = (((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
          (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1);
      if (v >= 4096) v -= 8192;
    end else if (op == 'h37 || op == 'h17) begin
      e.fmt = 3'd4;
      v = int'(ins & 32'hFFFFF000);
    end else if (op == 'h6F) begin
      e.fmt = 3'd5;
      v = (((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
          (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1);
      if (v >= (1 << 20)) v -= (1 << 21);
    end else if (op == 'h73) begin
      if (zicsr && f3 >= 5) begin
        e.fmt = 3'd6;
        v = (ins >> 15) & 31;
      end
    end else if (op == 'h33 || op == 'h0F || (op == 'h3B && XLEN == 64)) begin
      e.fmt = 3'd0;
    end else begin
      e.ill = 1'b1;
    end
    e.imm = v[XLEN-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [31:0] tg,
                               input bit ordy, input bit fl, input bit rs);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_tag    = tg;
    bus.out_ready = ordy;
    flush         = fl;
    rst           = rs;
  endtask

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops [13];
    logic [31:0] r;
    int pick;
    ops = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h73};
    r = $urandom;
    pick = $urandom_range(0, 15);
    if (pick < 13) r[6:0] = ops[pick];
    return r;
  endfunction

  // Compare process: checks the DUT against the model on every cycle, then
  // advances the model with the inputs that the next rising edge will see.
  initial begin : compareProc
    exp_t e;
    bit expReady;
    bit expValid;
    bit acc;
    bit fire;
    forever begin
      @(negedge clk);
      #2;
      expReady = !rst && (model.size() < 2);
      expValid = model.size() > 0;
      if (!done) begin
        checkOutput("in_ready", {63'b0, bus.in_ready}, {63'b0, expReady});
        checkOutput("out_valid", {63'b0, bus.out_valid}, {63'b0, expValid});
        if (expValid) begin
          checkOutput("out_tag", 64'(bus.out_tag), 64'(model[0].tag));
          checkOutput("out_imm", 64'(bus.out_imm), 64'(model[0].imm));
          checkOutput("out_fmt", 64'(bus.out_fmt), 64'(model[0].fmt));
          checkOutput("out_illegal", {63'b0, bus.out_illegal}, {63'b0, model[0].ill});
        end else if (zeroFlag) begin
          checkOutput("rst_zero", {bus.out_imm, bus.out_tag} | 64'({bus.out_fmt, bus.out_illegal}), 64'd0);
        end
      end
      if (rst) begin
        model.delete();
        zeroFlag = 1'b1;
      end else begin
        acc  = bus.in_valid && expReady;
        fire = expValid && bus.out_ready;
        if (flush) begin
          model.delete();
        end else begin
          if (fire) void'(model.pop_front());
          if (acc) begin
            modelDecode(bus.in_instr, e);
            e.tag = bus.in_tag;
            model.push_back(e);
            zeroFlag = 1'b0;
          end
        end
      end
    end
  end

  initial begin : mainProc
    exp_t p;
    nChecks       = 0;
    nFails        = 0;
    done          = 1'b0;
    zeroFlag      = 1'b1;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Pin the model itself with hand-computed decodes.
    modelDecode(32'hFFF00093, p);
    checkOutput("model_addi", {29'b0, p.fmt, p.imm}, {29'b0, 3'd1, 32'hFFFFFFFF});
    modelDecode(32'hFE000EE3, p);
    checkOutput("model_beq", {29'b0, p.fmt, p.imm}, {29'b0, 3'd3, 32'hFFFFFFFC});
    modelDecode(32'h4030D093, p);
    checkOutput("model_srai", {29'b0, p.fmt, p.imm}, {29'b0, 3'd1, 32'h00000003});
    modelDecode(32'h00000000, p);
    checkOutput("model_zero", {28'b0, p.ill, p.fmt, p.imm}, {28'b0, 1'b1, 3'd0, 32'h0});

    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);

    // Basic decode, one per cycle with downstream always ready.
    applyStimulus(1, 32'hFFF00093, 100, 1, 0, 0);
    applyStimulus(1, 32'hFE000EE3, 101, 1, 0, 0);
    #3;
    checkOutput("addi_valid", {63'b0, bus.out_valid}, 64'd1);
    checkOutput("addi_fmt", 64'(bus.out_fmt), 64'd1);
    checkOutput("addi_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
    applyStimulus(1, 32'h4030D093, 102, 1, 0, 0);
    #3;
    checkOutput("beq_fmt", 64'(bus.out_fmt), 64'd3);
    checkOutput("beq_imm", 64'(bus.out_imm), 64'hFFFFFFFC);
    applyStimulus(1, 32'h00000000, 103, 1, 0, 0);
    #3;
    checkOutput("srai_imm", 64'(bus.out_imm), 64'd3);
    applyStimulus(1, 32'h3002D073, 104, 1, 0, 0);
    #3;
    checkOutput("zero_illegal", {63'b0, bus.out_illegal}, 64'd1);
    checkOutput("zero_imm", 64'(bus.out_imm), 64'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #3;
`ifdef IMM_ZICSR_EN
    checkOutput("csr_fmt", 64'(bus.out_fmt), 64'd6);
    checkOutput("csr_imm", 64'(bus.out_imm), 64'd5);
`else
    checkOutput("csr_fmt", 64'(bus.out_fmt), 64'd0);
    checkOutput("csr_imm", 64'(bus.out_imm), 64'd0);
`endif
    checkOutput("csr_illegal", {63'b0, bus.out_illegal}, 64'd0);

    // Stalled downstream: two accepted, third refused, then drained in order.
    applyStimulus(1, 32'h00100093, 10, 0, 0, 0);
    applyStimulus(1, 32'h00200093, 11, 0, 0, 0);
    applyStimulus(1, 32'h00300093, 12, 0, 0, 0);
    #3;
    checkOutput("full_in_ready", {63'b0, bus.in_ready}, 64'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #3;
    checkOutput("drain_tag0", 64'(bus.out_tag), 64'd10);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #3;
    checkOutput("drain_tag1", 64'(bus.out_tag), 64'd11);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #3;
    checkOutput("drain_empty", {63'b0, bus.out_valid}, 64'd0);

    // Flush with both entries full and a new input offered.
    applyStimulus(1, 32'h00400093, 20, 0, 0, 0);
    applyStimulus(1, 32'h00500093, 21, 0, 0, 0);
    applyStimulus(1, 32'h00600093, 22, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #3;
    checkOutput("flush_valid", {63'b0, bus.out_valid}, 64'd0);
    checkOutput("flush_ready", {63'b0, bus.in_ready}, 64'd1);
    // Flush with one entry and an acceptable input: the input is dropped too.
    applyStimulus(1, 32'h00700093, 23, 0, 0, 0);
    applyStimulus(1, 32'h00800093, 24, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #3;
    checkOutput("flush_drop", {63'b0, bus.out_valid}, 64'd0);

    // Reset with skid full.
    applyStimulus(1, 32'h12345037, 30, 0, 0, 0);
    applyStimulus(1, 32'h0080006F, 31, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    #3;
    checkOutput("rst_valid", {63'b0, bus.out_valid}, 64'd0);
    checkOutput("rst_imm", 64'(bus.out_imm), 64'd0);
    checkOutput("rst_tag", 64'(bus.out_tag), 64'd0);
    checkOutput("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #3;
    checkOutput("post_rst_ready", {63'b0, bus.in_ready}, 64'd1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), randInstr(), $urandom,
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 149) == 0));
    end

    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    #3;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
